// File: rtl/threewire_arb.sv
// threewire_arb: two-requester round-robin front end for a 3-wire master.
// Ports:
//   in_clk, in_rst_n                  clock, async active-low reset
//   in_req_x, in_r_w_x, in_addr_x,
//   in_wr_data_x (x = a, b)           level request with command fields
//   out_ack_x, out_done_x             one-cycle accept / finish pulses
//   out_rd_data, out_err              read data, timeout abort flag
//   out_tw_start/_r_w/_addr/_wr_data  command to the 3-wire master
//   in_tw_busy, in_tw_rd_data         status/data from the 3-wire master
// Build option: define THREEWIRE_ARB_TIMEOUT_EN to enable the
// TIMEOUT_CYCLES watchdog on the START and BUSY wait states.
module threewire_arb #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        in_clk,
   input  logic        in_rst_n,
   input  logic        in_req_a,
   input  logic        in_req_b,
   input  logic        in_r_w_a,
   input  logic        in_r_w_b,
   input  logic [8:0]  in_addr_a,
   input  logic [8:0]  in_addr_b,
   input  logic [15:0] in_wr_data_a,
   input  logic [15:0] in_wr_data_b,
   output logic        out_ack_a,
   output logic        out_ack_b,
   output logic        out_done_a,
   output logic        out_done_b,
   output logic [15:0] out_rd_data,
   output logic        out_err,
   output logic        out_tw_start,
   output logic        out_tw_r_w,
   output logic [8:0]  out_tw_addr,
   output logic [15:0] out_tw_wr_data,
   input  logic        in_tw_busy,
   input  logic [15:0] in_tw_rd_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic        gnt_b_q, gnt_b_d;
   logic        last_b_q, last_b_d;
   logic        start_q, start_d;
   logic        r_w_q, r_w_d;
   logic [8:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rd_q, rd_d;
   logic        ack_a_q, ack_a_d;
   logic        ack_b_q, ack_b_d;
   logic        done_a_q, done_a_d;
   logic        done_b_q, done_b_d;
   logic        err_q, err_d;
   logic        pick_b;
   logic        to_hit;

   // B wins only if A is absent, or if A was the last one granted.
   assign pick_b = in_req_b & (~in_req_a | ~last_b_q);

`ifdef THREEWIRE_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          waiting;

   assign waiting = (state_q == S_START) || (state_q == S_BUSY);

   // Restart on every state change, so START and BUSY each get
   // their own full budget.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (waiting) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign to_hit = waiting &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_b_d  = gnt_b_q;
      last_b_d = last_b_q;
      start_d  = start_q;
      r_w_d    = r_w_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      ack_a_d  = 1'b0;
      ack_b_d  = 1'b0;
      done_a_d = 1'b0;
      done_b_d = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_req_a || in_req_b) begin
               state_d  = S_START;
               gnt_b_d  = pick_b;
               last_b_d = pick_b;
               start_d  = 1'b1;
               ack_a_d  = ~pick_b;
               ack_b_d  = pick_b;
               if (pick_b) begin
                  r_w_d   = in_r_w_b;
                  addr_d  = in_addr_b;
                  wdata_d = in_wr_data_b;
               end else begin
                  r_w_d   = in_r_w_a;
                  addr_d  = in_addr_a;
                  wdata_d = in_wr_data_a;
               end
            end
         end
         S_START: begin
            if (in_tw_busy) begin
               start_d = 1'b0;
               state_d = S_BUSY;
            end else if (to_hit) begin
               start_d  = 1'b0;
               state_d  = S_DONE;
               done_a_d = ~gnt_b_q;
               done_b_d = gnt_b_q;
               err_d    = 1'b1;
            end
         end
         S_BUSY: begin
            if (!in_tw_busy) begin
               state_d  = S_DONE;
               done_a_d = ~gnt_b_q;
               done_b_d = gnt_b_q;
               if (r_w_q) begin
                  rd_d = in_tw_rd_data;
               end
            end else if (to_hit) begin
               state_d  = S_DONE;
               done_a_d = ~gnt_b_q;
               done_b_d = gnt_b_q;
               err_d    = 1'b1;
            end
         end
         S_DONE: begin
            // The done pulse is registered and shows in this state;
            // no grant is taken here.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q  <= S_IDLE;
         gnt_b_q  <= 1'b0;
         last_b_q <= 1'b1;
         start_q  <= 1'b0;
         r_w_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= '0;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_b_q  <= gnt_b_d;
         last_b_q <= last_b_d;
         start_q  <= start_d;
         r_w_q    <= r_w_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
         err_q    <= err_d;
      end
   end

   assign out_ack_a      = ack_a_q;
   assign out_ack_b      = ack_b_q;
   assign out_done_a     = done_a_q;
   assign out_done_b     = done_b_q;
   assign out_rd_data    = rd_q;
   assign out_err        = err_q;
   assign out_tw_start   = start_q;
   assign out_tw_r_w     = r_w_q;
   assign out_tw_addr    = addr_q;
   assign out_tw_wr_data = wdata_q;

endmodule

// File: tb/tb_threewire_arb.sv
// tb_threewire_arb: scoreboard bench for threewire_arb with a
// behavioural 3-wire slave and a transaction-level reference model.
`timescale 1ns/1ps
module tb_threewire_arb;

`ifdef THREEWIRE_ARB_TIMEOUT_EN
   localparam int TO = 16;
   localparam int LONG_DUR = 12;
`else
   localparam int TO = 1024;
   localparam int LONG_DUR = 40;
`endif

   logic        clk, rst_n;
   logic        req_a, req_b, rw_a, rw_b;
   logic [8:0]  addr_a, addr_b;
   logic [15:0] wd_a, wd_b;
   logic        ack_a, ack_b, done_a, done_b, err;
   logic [15:0] rd_data;
   logic        tw_start, tw_rw, tw_busy;
   logic [8:0]  tw_addr;
   logic [15:0] tw_wd, tw_rd;

   threewire_arb #(.TIMEOUT_CYCLES(TO)) dut (
      .in_clk(clk), .in_rst_n(rst_n),
      .in_req_a(req_a), .in_req_b(req_b),
      .in_r_w_a(rw_a), .in_r_w_b(rw_b),
      .in_addr_a(addr_a), .in_addr_b(addr_b),
      .in_wr_data_a(wd_a), .in_wr_data_b(wd_b),
      .out_ack_a(ack_a), .out_ack_b(ack_b),
      .out_done_a(done_a), .out_done_b(done_b),
      .out_rd_data(rd_data), .out_err(err),
      .out_tw_start(tw_start), .out_tw_r_w(tw_rw),
      .out_tw_addr(tw_addr), .out_tw_wr_data(tw_wd),
      .in_tw_busy(tw_busy), .in_tw_rd_data(tw_rd)
   );

   typedef struct {
      bit          is_done;
      bit          side;
      bit          rw;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rd;
      bit          err;
   } exp_t;

   typedef struct {
      int          dly;
      int          dur;
      logic [15:0] data;
      bit          never;
   } slv_t;

   exp_t exp_q[$];
   slv_t slv_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   bit   last_b;
   logic [15:0] m_rd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void check(string nm, logic [31:0] act,
                                 logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Monitor: pops one expectation per ack or done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (ack_a || ack_b) begin
            check("ack_onehot", {31'd0, ack_a & ack_b}, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("ack_kind", {31'd0, e.is_done}, 0);
               check("ack_side", {31'd0, ack_b}, {31'd0, e.side});
               check("ack_start", {31'd0, tw_start}, 1);
               check("ack_rw", {31'd0, tw_rw}, {31'd0, e.rw});
               check("ack_addr", {23'd0, tw_addr}, {23'd0, e.addr});
               check("ack_wdata", {16'd0, tw_wd}, {16'd0, e.wdata});
            end
         end
         if (done_a || done_b) begin
            check("done_onehot", {31'd0, done_a & done_b}, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("done_kind", {31'd0, e.is_done}, 1);
               check("done_side", {31'd0, done_b}, {31'd0, e.side});
               check("done_rd", {16'd0, rd_data}, {16'd0, e.rd});
               check("done_err", {31'd0, err}, {31'd0, e.err});
               check("done_addr", {23'd0, tw_addr}, {23'd0, e.addr});
               check("done_rw", {31'd0, tw_rw}, {31'd0, e.rw});
            end
         end
      end
   end

   // 3-wire slave: serves each start pulse with the next config.
   initial begin
      slv_t c;
      bit   ab;
      tw_busy = 1'b0;
      tw_rd   = '0;
      forever begin
         @(negedge clk);
         if (rst_n && tw_start && slv_q.size() > 0) begin
            c  = slv_q.pop_front();
            ab = 1'b0;
            if (c.never) begin
               while (tw_start && rst_n) @(negedge clk);
            end else begin
               for (int i = 0; i < c.dly; i++) begin
                  @(negedge clk);
                  if (!rst_n) begin
                     ab = 1'b1;
                     break;
                  end
               end
               if (!ab) begin
                  tw_busy = 1'b1;
                  for (int i = 0; i < c.dur; i++) begin
                     @(negedge clk);
                     if (!rst_n) break;
                  end
                  tw_busy = 1'b0;
                  tw_rd   = c.data;
               end
            end
         end
      end
   end

   // Reference model: one accepted command yields an ack then a done;
   // reads return the slave word, writes and aborts keep the old word.
   task automatic predict(bit side, bit rw, logic [8:0] a,
                          logic [15:0] d, slv_t c);
      exp_t e;
      e.is_done = 1'b0;
      e.side    = side;
      e.rw      = rw;
      e.addr    = a;
      e.wdata   = d;
      e.rd      = '0;
      e.err     = 1'b0;
      exp_q.push_back(e);
      if (rw && !c.never) m_rd = c.data;
      e.is_done = 1'b1;
      e.rd      = m_rd;
      e.err     = c.never;
      exp_q.push_back(e);
      last_b = side;
      slv_q.push_back(c);
   endtask

   task automatic drive(bit side, bit rw, logic [8:0] a,
                        logic [15:0] d);
      if (side) begin
         rw_b = rw; addr_b = a; wd_b = d; req_b = 1'b1;
      end else begin
         rw_a = rw; addr_a = a; wd_a = d; req_a = 1'b1;
      end
   endtask

   task automatic run(int budget, bit lat_a, bit lat_b, bit glitch);
      int cyc = 0;
      int gl  = 0;
      bit gld = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && lat_a) begin
            check("lat_ack_a", {31'd0, ack_a}, 1);
            check("lat_start_a", {31'd0, tw_start}, 1);
         end
         if (cyc == 1 && lat_b) begin
            check("lat_ack_b", {31'd0, ack_b}, 1);
            check("lat_start_b", {31'd0, tw_start}, 1);
         end
         if (ack_a) req_a = 1'b0;
         if (ack_b) req_b = 1'b0;
         if (glitch && !gld && tw_busy) begin
            req_b = 1'b1; gl = 2; gld = 1'b1;
         end else if (gl > 0) begin
            gl--;
            if (gl == 0) req_b = 1'b0;
         end
         if (exp_q.size() == 0 && !req_a && !req_b) break;
         if (cyc >= budget) begin
            check("run_timeout", 1, 0);
            req_a = 1'b0; req_b = 1'b0;
            exp_q.delete(); slv_q.delete();
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic both(bit rwa, logic [8:0] aa, logic [15:0] da,
                       slv_t ca, bit rwb, logic [8:0] ab,
                       logic [15:0] db, slv_t cb);
      bit first_b;
      first_b = ~last_b;
      if (first_b) begin
         predict(1, rwb, ab, db, cb);
         predict(0, rwa, aa, da, ca);
      end else begin
         predict(0, rwa, aa, da, ca);
         predict(1, rwb, ab, db, cb);
      end
      drive(0, rwa, aa, da);
      drive(1, rwb, ab, db);
      run(400, ~first_b, first_b, 0);
   endtask

   task automatic chk_zero(string tag);
      check({tag, "_start"}, {31'd0, tw_start}, 0);
      check({tag, "_ack"}, {30'd0, ack_a, ack_b}, 0);
      check({tag, "_done"}, {30'd0, done_a, done_b}, 0);
      check({tag, "_err"}, {31'd0, err}, 0);
      check({tag, "_rd"}, {16'd0, rd_data}, 0);
      check({tag, "_tw"}, {6'd0, tw_rw, tw_addr, tw_wd}, 0);
   endtask

   function automatic slv_t mk(int dly, int dur, logic [15:0] d,
                               bit nv);
      slv_t c;
      c.dly = dly; c.dur = dur; c.data = d; c.never = nv;
      return c;
   endfunction

   initial begin
      int cnt;
      int k;
      slv_t c1, c2;
      rst_n = 1'b0;
      req_a = 0; req_b = 0; rw_a = 0; rw_b = 0;
      addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
      last_b = 1'b1;
      m_rd   = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;

      // Collision straight after reset: A first, then B.
      both(0, 9'h011, 16'h1111, mk(1, 3, 16'hAAAA, 0),
           1, 9'h022, 16'h2222, mk(2, 4, 16'hB0B0, 0));
      check("rr_last_b", {31'd0, last_b}, 1);

      // A write at 0x155 with a long busy window.
      predict(0, 0, 9'h155, 16'h00AA,
              mk(3, LONG_DUR, 16'hDEAD, 0));
      drive(0, 0, 9'h155, 16'h00AA);
      run(200, 1, 0, 0);
      check("wr_keeps_rd", {16'd0, rd_data}, 32'hB0B0);

      // B read at 0x0A0 returning 0x1234.
      predict(1, 1, 9'h0A0, 16'h0000, mk(1, 4, 16'h1234, 0));
      drive(1, 1, 9'h0A0, 16'h0000);
      run(200, 0, 1, 0);
      check("rd_1234", {16'd0, rd_data}, 32'h1234);

      // Reset in the middle of BUSY.
      begin
         exp_t e;
         e.is_done = 0; e.side = 0; e.rw = 1; e.addr = 9'h0F0;
         e.wdata = 16'h5A5A; e.rd = '0; e.err = 0;
         exp_q.push_back(e);
         slv_q.push_back(mk(1, 30, 16'h7777, 0));
         drive(0, 1, 9'h0F0, 16'h5A5A);
         cnt = 0;
         while (!tw_busy && cnt < 50) begin
            @(negedge clk);
            if (ack_a) req_a = 1'b0;
            cnt++;
         end
         check("rst_reach_busy", {31'd0, tw_busy}, 1);
         repeat (3) @(negedge clk);
         #1 rst_n = 1'b0;
         #1 chk_zero("midrst");
         @(negedge clk);
         @(negedge clk);
         check("midrst_q", exp_q.size(), 0);
         rst_n = 1'b1;
         last_b = 1'b1;
         m_rd   = '0;
         slv_q.delete();
         @(negedge clk);
      end
      predict(0, 1, 9'h033, 16'h0, mk(0, 3, 16'hC3C3, 0));
      drive(0, 1, 9'h033, 16'h0);
      run(200, 1, 0, 0);

`ifdef THREEWIRE_ARB_TIMEOUT_EN
      // Slave never answers: watchdog aborts after TO cycles.
      predict(0, 1, 9'h1FF, 16'h0, mk(0, 0, 16'h0, 1));
      drive(0, 1, 9'h1FF, 16'h0);
      @(negedge clk);
      if (ack_a) req_a = 1'b0;
      cnt = 0;
      while (tw_start && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("to_start_cycles", cnt, TO);
      run(50, 0, 0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         k  = $urandom_range(0, 3);
         c1 = mk($urandom_range(0, 4), $urandom_range(3, 8),
                 16'($urandom), 0);
         c2 = mk($urandom_range(0, 4), $urandom_range(3, 8),
                 16'($urandom), 0);
         case (k)
            0, 3: begin
               predict(0, 1'($urandom), 9'($urandom),
                       16'($urandom), c1);
               drive(0, exp_q[0].rw, exp_q[0].addr,
                     exp_q[0].wdata);
               run(200, 1, 0, k == 3);
            end
            1: begin
               predict(1, 1'($urandom), 9'($urandom),
                       16'($urandom), c1);
               drive(1, exp_q[0].rw, exp_q[0].addr,
                     exp_q[0].wdata);
               run(200, 0, 1, 0);
            end
            default: begin
               both(1'($urandom), 9'($urandom), 16'($urandom), c1,
                    1'($urandom), 9'($urandom), 16'($urandom), c2);
            end
         endcase
      end

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
